// File: rtl/pingpong_pkg.sv
// Shared encodings and width helper for the ping-pong bank buffer.
// Bank states are stored per bank; writer and reader FSMs use their own state types.
package pingpong_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    READY    = 2'd1,
    DRAINING = 2'd2
  } bank_state_t;

  typedef enum logic {
    W_FILL  = 1'b0,
    W_STALL = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rd_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/pp_bank_mem.sv
// NBANKS x DEPTH sample store: one synchronous write port, one combinational read port.
// Zero-latency read; no flow control, the caller guarantees write and read target different banks.
module pp_bank_mem
  import pingpong_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int NBANKS = 2
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic [clog2(NBANKS)-1:0]  i_wbank,
  input  logic [clog2(DEPTH)-1:0]   i_widx,
  input  logic [DATA_W-1:0]         i_wdata,
  input  logic [clog2(NBANKS)-1:0]  i_rbank,
  input  logic [clog2(DEPTH)-1:0]   i_ridx,
  output logic [DATA_W-1:0]         o_rdata
);

  logic [DATA_W-1:0] r_mem [NBANKS][DEPTH];

  // Contents survive reset; bank state alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wbank][i_widx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_rbank][i_ridx];

endmodule

// File: rtl/pingpong_bank_buffer.sv
// N-bank ping-pong sample buffer: fills one bank while a completed bank drains as a valid/ready burst.
// First word 2 edges after bank close; output holds under backpressure, input samples drop when no bank is free.
module pingpong_bank_buffer
  import pingpong_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int NBANKS = 2
) (
  input  logic                       sysclk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic [clog2(NBANKS)-1:0]   out_bank,
  output logic [clog2(NBANKS+1)-1:0] ready_cnt,
  output logic [15:0]                drop_cnt,
  output logic                       overflow,
  input  logic                       clr_stats
);

  localparam int BW = clog2(NBANKS);
  localparam int IW = clog2(DEPTH);
  localparam int LW = IW + 1;
  localparam int CW = clog2(NBANKS + 1);

  bank_state_t       r_bstate [NBANKS];
  logic [LW-1:0]     r_len    [NBANKS];
  wr_state_t         r_wstate, w_wstate_nxt;
  rd_state_t         r_rstate, w_rstate_nxt;
  logic [BW-1:0]     r_wbank, r_rbank, w_wbank_nxt, w_rbank_nxt;
  logic [IW-1:0]     r_widx, r_ridx, w_rd_idx;
  logic              w_wr_ok, w_we, w_close, w_drop;
  logic [LW-1:0]     w_close_len;
  logic              w_start, w_adv, w_done, w_next_last;
  logic [DATA_W-1:0] w_rdata;

  pp_bank_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NBANKS(NBANKS)) u_mem (
    .i_clk   (sysclk),
    .i_we    (w_we),
    .i_wbank (r_wbank),
    .i_widx  (r_widx),
    .i_wdata (in_data),
    .i_rbank (r_rbank),
    .i_ridx  (w_rd_idx),
    .o_rdata (w_rdata)
  );

  assign w_wbank_nxt = (r_wbank == BW'(NBANKS - 1)) ? '0 : r_wbank + BW'(1);
  assign w_rbank_nxt = (r_rbank == BW'(NBANKS - 1)) ? '0 : r_rbank + BW'(1);
  assign w_next_last = (LW'(w_rd_idx) == r_len[r_rbank] - LW'(1));

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      r_wstate <= W_FILL;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  // A stalled writer resumes in the same cycle its bank is seen EMPTY.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_we         = 1'b0;
    w_close      = 1'b0;
    w_drop       = 1'b0;
    w_close_len  = LW'(r_widx);
    w_wr_ok      = (r_wstate == W_FILL) || (r_bstate[r_wbank] == EMPTY);
    if (w_wr_ok) begin
      w_we         = in_valid;
      w_wstate_nxt = W_FILL;
      if (in_valid && (flush || r_widx == IW'(DEPTH - 1))) begin
        w_close     = 1'b1;
        w_close_len = LW'(r_widx) + LW'(1);
      end else if (flush && r_widx != '0) begin
        w_close = 1'b1;
      end
      if (w_close && r_bstate[w_wbank_nxt] != EMPTY) w_wstate_nxt = W_STALL;
    end else begin
      w_drop = in_valid;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_start      = 1'b0;
    w_adv        = 1'b0;
    w_done       = 1'b0;
    w_rd_idx     = '0;
    case (r_rstate)
      R_IDLE: begin
        if (r_bstate[r_rbank] == READY) begin
          w_start      = 1'b1;
          w_rstate_nxt = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (out_ready) begin
          if (out_last) begin
            w_done       = 1'b1;
            w_rstate_nxt = R_IDLE;
          end else begin
            w_adv    = 1'b1;
            w_rd_idx = r_ridx + IW'(1);
          end
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Writer and reader never touch the same bank entry in one cycle.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      r_wbank   <= '0;
      r_widx    <= '0;
      r_rbank   <= '0;
      r_ridx    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_bank  <= '0;
      for (int b = 0; b < NBANKS; b++) begin
        r_bstate[b] <= EMPTY;
        r_len[b]    <= '0;
      end
    end else begin
      if (w_close) begin
        r_bstate[r_wbank] <= READY;
        r_len[r_wbank]    <= w_close_len;
        r_wbank           <= w_wbank_nxt;
        r_widx            <= '0;
      end else if (w_we) begin
        r_widx <= r_widx + IW'(1);
      end
      if (w_start) begin
        r_bstate[r_rbank] <= DRAINING;
        out_valid         <= 1'b1;
        out_bank          <= r_rbank;
      end
      if (w_start || w_adv) begin
        r_ridx   <= w_rd_idx;
        out_data <= w_rdata;
        out_last <= w_next_last;
      end
      if (w_done) begin
        r_bstate[r_rbank] <= EMPTY;
        out_valid         <= 1'b0;
        out_last          <= 1'b0;
        r_rbank           <= w_rbank_nxt;
      end
    end
  end

  always_comb begin
    ready_cnt = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (r_bstate[b] != EMPTY) ready_cnt = ready_cnt + CW'(1);
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clr_stats) begin
      drop_cnt <= {15'd0, w_drop};
      overflow <= w_drop;
    end else if (w_drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pingpong_bank_buffer.sv
// Bench for pingpong_bank_buffer (DEPTH=4, NBANKS=2): cycle vector table plus scoreboarded burst scenarios.
module tb_pingpong_bank_buffer;

  logic        sysclk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_stats = 1'b0;
  logic        out_valid, out_last, overflow;
  logic [15:0] out_data, drop_cnt;
  logic [0:0]  out_bank;
  logic [1:0]  ready_cnt;

  always #5 sysclk = ~sysclk;

  pingpong_bank_buffer #(.DATA_W(16), .DEPTH(4), .NBANKS(2)) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_bank  (out_bank),
    .ready_cnt (ready_cnt),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow),
    .clr_stats (clr_stats)
  );

  typedef struct {
    logic [15:0] d;
    logic        last;
    logic        bank;
  } exp_t;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        f;
    logic        e_ov;
    logic [15:0] e_od;
    logic        e_ol;
    logic        e_ob;
    logic [1:0]  e_rc;
  } vec_t;

  exp_t sb[$];
  vec_t tq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  // Every accepted beat must match the head of the expected queue.
  always @(negedge sysclk) begin
    if (mon_en && rst && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra: got data=%h last=%b bank=%b, expected no beat", out_data, out_last, out_bank);
      end else begin
        mon_e = sb.pop_front();
        if ({out_data, out_last, out_bank} !== {mon_e.d, mon_e.last, mon_e.bank}) begin
          n_err++;
          $display("FAIL sb_beat: got data=%h last=%b bank=%b, expected data=%h last=%b bank=%b",
                   out_data, out_last, out_bank, mon_e.d, mon_e.last, mon_e.bank);
        end
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic write(input logic [15:0] d, input logic last, input logic bank, input logic push);
    if (push) sb.push_back('{d, last, bank});
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    clr_stats = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    tick();
    tick();
    chk("rst_state", 32'({out_valid, out_last, out_bank, ready_cnt, overflow}), 32'd0);
    chk("rst_data", 32'({out_data, drop_cnt}), 32'd0);
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while ((sb.size() != 0 || out_valid) && c < budget) begin
      tick();
      c++;
    end
    n_vec++;
    if (sb.size() != 0 || out_valid) begin
      n_err++;
      $display("FAIL %s: got %0d beats outstanding, out_valid=%b after %0d cycles, expected 0 and 0",
               name, sb.size(), out_valid, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within time limit, expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Basic drain, flush, idle flush, flush together with a write.
    tq.push_back('{1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});
    tq.push_back('{1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});
    tq.push_back('{1'b1, 16'h0003, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});
    tq.push_back('{1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd1});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 2'd1});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 2'd1});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 2'd1});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 2'd1});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});
    tq.push_back('{1'b1, 16'h000A, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});
    tq.push_back('{1'b1, 16'h000B, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});
    tq.push_back('{1'b1, 16'h000C, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});
    tq.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd1});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h000A, 1'b0, 1'b1, 2'd1});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h000B, 1'b0, 1'b1, 2'd1});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h000C, 1'b1, 1'b1, 2'd1});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});
    tq.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});
    tq.push_back('{1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});
    tq.push_back('{1'b1, 16'h0012, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd1});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0011, 1'b0, 1'b0, 2'd1});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0012, 1'b1, 1'b0, 2'd1});
    tq.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0});

    out_ready = 1'b1;
    for (int i = 0; i < tq.size(); i++) begin
      in_valid = tq[i].v;
      in_data  = tq[i].d;
      flush    = tq[i].f;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      n_vec++;
      if (out_valid !== tq[i].e_ov || ready_cnt !== tq[i].e_rc || drop_cnt !== 16'd0 || overflow !== 1'b0 ||
          (tq[i].e_ov && (out_data !== tq[i].e_od || out_last !== tq[i].e_ol || out_bank !== tq[i].e_ob))) begin
        n_err++;
        $display("FAIL vec%0d: got v=%b d=%h l=%b b=%b rc=%0d drop=%0d ovf=%b, expected v=%b d=%h l=%b b=%b rc=%0d drop=0 ovf=0",
                 i, out_valid, out_data, out_last, out_bank, ready_cnt, drop_cnt, overflow,
                 tq[i].e_ov, tq[i].e_od, tq[i].e_ol, tq[i].e_ob, tq[i].e_rc);
      end
    end

    // Ping-pong: spaced strobes alternate banks.
    do_reset();
    out_ready = 1'b1;
    mon_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      write(16'(i), (i % 4 == 0), (i > 4), 1'b1);
      tick();
      tick();
    end
    wait_drain("pingpong_drain", 50);
    chk("pingpong_drop", 32'({overflow, drop_cnt}), 32'd0);

    // Backpressure: first word held while out_ready is low.
    do_reset();
    for (int i = 1; i <= 4; i++) write(16'(32'h100 + i), (i == 4), 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold", 32'({out_valid, out_last, ready_cnt, out_data}), 32'({1'b1, 1'b0, 2'd1, 16'h0101}));
      tick();
    end
    out_ready = 1'b1;
    repeat (4) tick();
    chk("bp_burst_len", 32'({sb.size() == 0, out_valid}), 32'd2);

    // Overflow: two samples dropped once both banks are occupied.
    do_reset();
    for (int i = 1; i <= 10; i++) write(16'(32'h200 + i), (i % 4 == 0), (i > 4), (i <= 8));
    chk("ovf_stats", 32'({overflow, drop_cnt}), 32'({1'b1, 16'd2}));
    chk("ovf_ready_cnt", 32'(ready_cnt), 32'd2);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("ovf_clr", 32'({overflow, drop_cnt}), 32'd0);
    clr_stats = 1'b1;
    write(16'h02FF, 1'b0, 1'b0, 1'b0);
    clr_stats = 1'b0;
    chk("ovf_clr_drop", 32'({overflow, drop_cnt}), 32'({1'b1, 16'd1}));
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    out_ready = 1'b1;
    wait_drain("ovf_drain", 60);
    chk("ovf_after_drain", 32'({overflow, drop_cnt}), 32'd0);
    for (int i = 1; i <= 4; i++) write(16'(32'h500 + i), (i == 4), 1'b0, 1'b1);
    wait_drain("stall_recover", 30);

    // Reset in the middle of a burst.
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) write(16'(32'h300 + i), (i == 4), 1'b0, 1'b1);
    tick();
    tick();
    chk("rst_mid_pre", 32'({out_valid, out_data}), 32'({1'b1, 16'h0302}));
    rst = 1'b0;
    #1;
    chk("rst_mid_outs", 32'({out_valid, out_last, out_bank, ready_cnt, overflow}), 32'd0);
    chk("rst_mid_data", 32'({out_data, drop_cnt}), 32'd0);
    sb.delete();
    tick();
    rst = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) write(16'(32'h400 + i), (i == 4), 1'b0, 1'b1);
    wait_drain("rst_fresh_drain", 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
